axi_mem_slv: RTL



---
 rtl/axi_mem_slv_pkg.sv | 23 ++
 rtl/axi_mem_slv_addr.sv | 49 ++++
 rtl/axi_mem_slv.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_mem_slv_pkg.sv
// Shared AXI typedefs and encodings used by the memory slave and its
// address helper: beat length/size/burst/response types plus the response
// and burst-type constants.
package axi_mem_slv_pkg;

  typedef logic [7:0] len_t;
  typedef logic [2:0] size_t;
  typedef logic [1:0] burst_t;
  typedef logic [1:0] resp_t;

  localparam resp_t  RESP_OKAY   = 2'b00;
  localparam resp_t  RESP_SLVERR = 2'b10;

  localparam burst_t BURST_FIXED = 2'b00;
  localparam burst_t BURST_INCR  = 2'b01;
  localparam burst_t BURST_WRAP  = 2'b10;

  // Only FIXED and INCR are served; WRAP and the reserved code are errors.
  function automatic logic burst_supported(input burst_t burst);
    return (burst == BURST_FIXED) || (burst == BURST_INCR);
  endfunction

endpackage

// File: rtl/axi_mem_slv_addr.sv
// axi_burst_addr: combinational per-beat address helper.
// Given the address of the current beat plus the burst size/type it returns
// the address of the following beat, the memory word index of the current
// beat, and an error flag covering unsupported burst type, a size wider than
// the data bus, and an address beyond the end of the memory.
//   addr      in  current beat address
//   size      in  AxSIZE
//   burst     in  AxBURST
//   next_addr out address of the following beat
//   word_idx  out memory word selected by addr
//   beat_err  out this beat must be answered with SLVERR
module axi_burst_addr
  import axi_mem_slv_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64,
  parameter int MEM_WORDS = 1024,
  localparam int OFF      = $clog2(DATA_W / 8),
  localparam int IDX_W    = $clog2(MEM_WORDS)
) (
  input  logic [ADDR_W-1:0] addr,
  input  size_t             size,
  input  burst_t            burst,
  output logic [ADDR_W-1:0] next_addr,
  output logic [IDX_W-1:0]  word_idx,
  output logic              beat_err
);

  // Byte size of the memory; compared in 64 bits so it never aliases onto
  // the address width.
  localparam logic [63:0] LIMIT = 64'(MEM_WORDS) * 64'(DATA_W / 8);

  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] aligned;
  logic              out_of_range;
  logic              bad_size;

  always_comb begin
    step         = ADDR_W'(1) << size;
    aligned      = addr & ~(step - ADDR_W'(1));
    next_addr    = (burst == BURST_INCR) ? (aligned + step) : addr;
    out_of_range = (64'(addr) >= LIMIT);
    bad_size     = (int'(size) > OFF);
    beat_err     = out_of_range | bad_size | ~burst_supported(burst);
  end

  assign word_idx = addr[OFF +: IDX_W];

endmodule

// File: rtl/axi_mem_slv.sv
// axi_mem_slv: AXI4 memory slave terminating one crossbar master port.
// Independent write and read FSMs, one outstanding transaction each, sharing
// a single word-addressed memory. All outputs come straight from flops.
//   clk, rst_n                 clock, asynchronous active-low reset
//   aw_* / aw_valid, aw_ready  write address channel (aw_atop != 0 -> SLVERR)
//   w_*  / w_valid,  w_ready   write data channel, byte lanes by w_strb
//   b_*  / b_valid,  b_ready   write response channel
//   ar_* / ar_valid, ar_ready  read address channel
//   r_*  / r_valid,  r_ready   read data channel, r_resp per beat
//
// Handshake rule on every channel: a transfer happens on a rising clk edge
// where valid and ready are both 1. The sender holds valid and its payload
// unchanged until that edge; ready may change freely and never depends on
// valid combinationally.
module axi_mem_slv
  import axi_mem_slv_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int MEM_WORDS      = 1024,
  localparam int STRB          = AXI_DATA_WIDTH / 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [AXI_ID_WIDTH-1:0]   aw_id,
  input  logic [AXI_ADDR_WIDTH-1:0] aw_addr,
  input  len_t                      aw_len,
  input  size_t                     aw_size,
  input  burst_t                    aw_burst,
  input  logic [5:0]                aw_atop,
  input  logic                      aw_valid,
  output logic                      aw_ready,
  input  logic [AXI_DATA_WIDTH-1:0] w_data,
  input  logic [STRB-1:0]           w_strb,
  input  logic                      w_last,
  input  logic                      w_valid,
  output logic                      w_ready,
  output logic [AXI_ID_WIDTH-1:0]   b_id,
  output resp_t                     b_resp,
  output logic                      b_valid,
  input  logic                      b_ready,
  input  logic [AXI_ID_WIDTH-1:0]   ar_id,
  input  logic [AXI_ADDR_WIDTH-1:0] ar_addr,
  input  len_t                      ar_len,
  input  size_t                     ar_size,
  input  burst_t                    ar_burst,
  input  logic                      ar_valid,
  output logic                      ar_ready,
  output logic [AXI_ID_WIDTH-1:0]   r_id,
  output logic [AXI_DATA_WIDTH-1:0] r_data,
  output resp_t                     r_resp,
  output logic                      r_last,
  output logic                      r_valid,
  input  logic                      r_ready
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  logic [AXI_DATA_WIDTH-1:0] mem [MEM_WORDS];

  // ---------------------------------------------------------------- write
  logic [1:0]                w_state;
  logic [AXI_ID_WIDTH-1:0]   w_id_q;
  logic [AXI_ADDR_WIDTH-1:0] w_addr_q;
  len_t                      w_len_q;
  len_t                      w_cnt_q;
  size_t                     w_size_q;
  burst_t                    w_burst_q;
  logic                      w_err_q;

  logic [AXI_ADDR_WIDTH-1:0] w_next;
  logic [IDX_W-1:0]          w_idx;
  logic                      w_addr_err;
  logic                      w_hs;
  logic                      w_beat_err;
  logic                      w_we;

  axi_burst_addr #(
    .ADDR_W    (AXI_ADDR_WIDTH),
    .DATA_W    (AXI_DATA_WIDTH),
    .MEM_WORDS (MEM_WORDS)
  ) u_w_addr (
    .addr      (w_addr_q),
    .size      (w_size_q),
    .burst     (w_burst_q),
    .next_addr (w_next),
    .word_idx  (w_idx),
    .beat_err  (w_addr_err)
  );

  assign w_hs = w_valid & w_ready;
  // w_last must coincide with beat len; a mismatch either way is an error
  // from that beat on. w_err_q is sticky, so counter wrap on an over-long
  // burst cannot clear it.
  assign w_beat_err = w_err_q | w_addr_err | (w_last != (w_cnt_q == w_len_q));
  assign w_we       = w_hs & ~w_beat_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state   <= W_IDLE;
      aw_ready  <= 1'b0;
      w_ready   <= 1'b0;
      b_valid   <= 1'b0;
      b_resp    <= RESP_OKAY;
      b_id      <= '0;
      w_id_q    <= '0;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_cnt_q   <= '0;
      w_size_q  <= '0;
      w_burst_q <= '0;
      w_err_q   <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          aw_ready <= 1'b1;
          if (aw_valid && aw_ready) begin
            aw_ready  <= 1'b0;
            w_ready   <= 1'b1;
            w_id_q    <= aw_id;
            w_addr_q  <= aw_addr;
            w_len_q   <= aw_len;
            w_size_q  <= aw_size;
            w_burst_q <= aw_burst;
            w_cnt_q   <= '0;
            w_err_q   <= (aw_atop != 6'd0);
            w_state   <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            w_addr_q <= w_next;
            w_cnt_q  <= w_cnt_q + 8'd1;
            w_err_q  <= w_beat_err;
            if (w_last) begin
              w_ready <= 1'b0;
              b_valid <= 1'b1;
              b_id    <= w_id_q;
              b_resp  <= w_beat_err ? RESP_SLVERR : RESP_OKAY;
              w_state <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (b_valid && b_ready) begin
            b_valid  <= 1'b0;
            aw_ready <= 1'b1;
            w_state  <= W_IDLE;
          end
        end
        default: begin
          aw_ready <= 1'b0;
          w_ready  <= 1'b0;
          b_valid  <= 1'b0;
          w_state  <= W_IDLE;
        end
      endcase
    end
  end

  // Memory contents are not reset; byte lanes are written in place.
  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int b = 0; b < STRB; b++) begin
        if (w_strb[b]) mem[w_idx][b*8 +: 8] <= w_data[b*8 +: 8];
      end
    end
  end

  // ----------------------------------------------------------------- read
  logic [0:0]                r_state;
  logic [AXI_ADDR_WIDTH-1:0] r_addr_q;   // address of the next beat to fetch
  len_t                      r_len_q;
  len_t                      r_cnt_q;
  size_t                     r_size_q;
  burst_t                    r_burst_q;

  logic [AXI_ADDR_WIDTH-1:0] rf_addr;
  size_t                     rf_size;
  burst_t                    rf_burst;
  logic [AXI_ADDR_WIDTH-1:0] rf_next;
  logic [IDX_W-1:0]          rf_idx;
  logic                      rf_err;
  len_t                      r_cnt_nxt;

  // Beat 0 is fetched straight from the AR channel so it is presented one
  // cycle after the AR handshake; later beats come from the stored address.
  assign rf_addr   = (r_state == R_IDLE) ? ar_addr  : r_addr_q;
  assign rf_size   = (r_state == R_IDLE) ? ar_size  : r_size_q;
  assign rf_burst  = (r_state == R_IDLE) ? ar_burst : r_burst_q;
  assign r_cnt_nxt = r_cnt_q + 8'd1;

  axi_burst_addr #(
    .ADDR_W    (AXI_ADDR_WIDTH),
    .DATA_W    (AXI_DATA_WIDTH),
    .MEM_WORDS (MEM_WORDS)
  ) u_r_addr (
    .addr      (rf_addr),
    .size      (rf_size),
    .burst     (rf_burst),
    .next_addr (rf_next),
    .word_idx  (rf_idx),
    .beat_err  (rf_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= R_IDLE;
      ar_ready  <= 1'b0;
      r_valid   <= 1'b0;
      r_last    <= 1'b0;
      r_resp    <= RESP_OKAY;
      r_data    <= '0;
      r_id      <= '0;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_cnt_q   <= '0;
      r_size_q  <= '0;
      r_burst_q <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          ar_ready <= 1'b1;
          if (ar_valid && ar_ready) begin
            ar_ready  <= 1'b0;
            r_valid   <= 1'b1;
            r_id      <= ar_id;
            r_len_q   <= ar_len;
            r_cnt_q   <= '0;
            r_size_q  <= ar_size;
            r_burst_q <= ar_burst;
            r_addr_q  <= rf_next;
            r_data    <= rf_err ? '0 : mem[rf_idx];
            r_resp    <= rf_err ? RESP_SLVERR : RESP_OKAY;
            r_last    <= (ar_len == 8'd0);
            r_state   <= R_DATA;
          end
        end
        R_DATA: begin
          if (r_valid && r_ready) begin
            if (r_last) begin
              r_valid  <= 1'b0;
              r_last   <= 1'b0;
              ar_ready <= 1'b1;
              r_state  <= R_IDLE;
            end else begin
              r_cnt_q  <= r_cnt_nxt;
              r_addr_q <= rf_next;
              r_data   <= rf_err ? '0 : mem[rf_idx];
              r_resp   <= rf_err ? RESP_SLVERR : RESP_OKAY;
              r_last   <= (r_cnt_nxt == r_len_q);
            end
          end
        end
        default: begin
          ar_ready <= 1'b0;
          r_valid  <= 1'b0;
          r_state  <= R_IDLE;
        end
      endcase
    end
  end

endmodule
